uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver, the next-generation replacement for the fixed 8-bit receiver in the serial subsystem. It supports 5..9 data bits, optional even/odd parity, and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote at mid-bit. It flags parity errors, framing errors and line breaks with separate outputs. The block sits between the RX pad (after no other logic) and the register/FIFO layer, which consumes a one-cycle DATA_VALID strobe.

---
 rtl/uart_rx_cfg.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// 3-sample mid-bit majority vote, separate parity/framing/break reporting.
module uart_rx_cfg #(
    parameter int DATA_WIDTH_MAX = 9,
    parameter int PRESCALE_W     = 9,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_W-1:0]     PRESCALE,
    input  logic [3:0]                DATA_LEN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    output logic [DATA_WIDTH_MAX-1:0] P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      FRM_ERR,
    output logic                      BRK_DET,
    output logic                      BUSY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_BRKWAIT = 3'd5;

    localparam logic [3:0]            LEN_MAX   = 4'(DATA_WIDTH_MAX);
    localparam logic [PRESCALE_W-1:0] PRESC_MIN = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);

    logic [SYNC_STAGES-1:0]    r_sync;
    logic [2:0]                r_state;
    logic [PRESCALE_W-1:0]     r_cnt;
    logic [PRESCALE_W-1:0]     r_presc;
    logic [3:0]                r_len;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic                      r_stop2;
    logic [3:0]                r_bitidx;
    logic                      r_stopidx;
    logic                      r_s0;
    logic                      r_s1;
    logic [DATA_WIDTH_MAX-1:0] r_data;
    logic                      r_par_bit;
    logic                      r_stop1_bit;
    logic                      r_par_bad;
    logic                      r_frm_bad;
    logic [DATA_WIDTH_MAX-1:0] r_p_data;
    logic                      r_data_valid;
    logic                      r_par_err;
    logic                      r_frm_err;
    logic                      r_brk_det;

    logic                      w_rx_s;
    logic                      w_go;
    logic                      w_framing;
    logic [PRESCALE_W-1:0]     w_half;
    logic                      w_mid;
    logic                      w_end;
    logic                      w_vote;
    logic                      w_par_exp;
    logic                      w_brk;
    logic [PRESCALE_W-1:0]     w_presc_clamp;
    logic [3:0]                w_len_clamp;
    logic [DATA_WIDTH_MAX-1:0] w_data_next;

    assign w_rx_s        = r_sync[SYNC_STAGES-1];
    assign w_go          = (r_state == S_IDLE) && !w_rx_s;
    assign w_framing     = (r_state != S_IDLE) && (r_state != S_BRKWAIT);
    assign w_half        = r_presc >> 1;
    assign w_mid         = (r_cnt == w_half + ONE);
    assign w_end         = (r_cnt == r_presc - ONE);
    assign w_vote        = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_par_exp     = r_par_typ ? ^r_data : ~^r_data;
    assign w_brk         = (r_data == '0) && (!r_par_en || !r_par_bit) && !r_stop1_bit;
    assign w_presc_clamp = (PRESCALE < PRESC_MIN) ? PRESC_MIN : PRESCALE;
    assign w_len_clamp   = (DATA_LEN < 4'd5) ? 4'd5 : ((DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN);

    // Each data bit is written at its own index, so short frames stay zero-extended.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH_MAX; gi++) begin : g_data
            assign w_data_next[gi] = (r_state == S_DATA && w_mid && r_bitidx == 4'(gi))
                                     ? w_vote : r_data[gi];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_presc      <= PRESC_MIN;
            r_len        <= 4'd5;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_stop2      <= 1'b0;
            r_bitidx     <= '0;
            r_stopidx    <= 1'b0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_data       <= '0;
            r_par_bit    <= 1'b0;
            r_stop1_bit  <= 1'b0;
            r_par_bad    <= 1'b0;
            r_frm_bad    <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_brk_det    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_brk_det    <= 1'b0;
            r_data       <= w_go ? '0 : w_data_next;

            if (w_framing) begin
                r_cnt <= w_end ? '0 : r_cnt + ONE;
                if (r_cnt == w_half - ONE) r_s0 <= w_rx_s;
                if (r_cnt == w_half)       r_s1 <= w_rx_s;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state     <= S_START;
                        r_presc     <= w_presc_clamp;
                        r_len       <= w_len_clamp;
                        r_par_en    <= PAR_EN;
                        r_par_typ   <= PAR_TYP;
                        r_stop2     <= STOP2;
                        r_bitidx    <= '0;
                        r_stopidx   <= 1'b0;
                        r_par_bit   <= 1'b0;
                        r_stop1_bit <= 1'b0;
                        r_par_bad   <= 1'b0;
                        r_frm_bad   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_mid && w_vote) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid) r_bitidx <= r_bitidx + 4'd1;
                    if (w_end && r_bitidx == r_len) r_state <= r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_mid) begin
                        r_par_bit <= w_vote;
                        r_par_bad <= (w_vote != w_par_exp);
                    end
                    if (w_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_mid) begin
                        if (!w_vote)    r_frm_bad   <= 1'b1;
                        if (!r_stopidx) r_stop1_bit <= w_vote;
                    end
                    if (w_end) begin
                        if (r_stop2 && !r_stopidx) begin
                            r_stopidx <= 1'b1;
                        end else if (w_brk) begin
                            r_brk_det <= 1'b1;
                            r_state   <= S_BRKWAIT;
                        end else begin
                            r_p_data     <= r_data;
                            r_data_valid <= 1'b1;
                            r_par_err    <= r_par_bad;
                            r_frm_err    <= r_frm_bad;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_BRKWAIT: begin
                    // A full bit period of idle-high line is required; any low restarts it.
                    if (!w_rx_s) begin
                        r_cnt <= '0;
                    end else if (w_end) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_data_valid;
    assign PAR_ERR    = r_par_err;
    assign FRM_ERR    = r_frm_err;
    assign BRK_DET    = r_brk_det;
    assign BUSY       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frame-level model predicts each strobe; directed frames
// cover parity, framing, false start, break, noise, reset and config clamping.
module tb_uart_rx_cfg;
    localparam int DW = 9;
    localparam int PW = 9;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] PRESCALE = PW'(16);
    logic [3:0]    DATA_LEN = 4'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID, PAR_ERR, FRM_ERR, BRK_DET, BUSY;

    uart_rx_cfg #(.DATA_WIDTH_MAX(DW), .PRESCALE_W(PW), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .DATA_LEN(DATA_LEN),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR),
        .BRK_DET(BRK_DET), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            brk;
        logic [DW-1:0] data;
        bit            perr;
        bit            ferr;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad = 0;
    int            n_valid = 0;
    int            n_brk = 0;
    logic [DW-1:0] last_data = '0;
    bit            last_perr = 0;
    bit            last_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Frame-level prediction from the levels actually placed on the line.
    function automatic exp_t model(input int len_in, input bit pen, input bit ptyp, input bit st2,
                                   input logic [DW-1:0] d, input bit pbit, input bit [1:0] stops);
        exp_t e;
        int   len;
        logic [DW-1:0] m;
        len = (len_in < 5) ? 5 : ((len_in > DW) ? DW : len_in);
        m = d & DW'((1 << len) - 1);
        e.data = m;
        e.perr = pen && (pbit != (ptyp ? ^m : ~^m));
        e.ferr = !stops[0] || (st2 && !stops[1]);
        e.brk  = (m == '0) && (!pen || !pbit) && !stops[0];
        return e;
    endfunction

    always @(negedge CLK) begin : cmp
        exp_t e;
        if (RST) begin
            if (!DATA_VALID) check("flags_without_valid", {PAR_ERR, FRM_ERR}, 0);
            if (DATA_VALID || BRK_DET) begin
                if (DATA_VALID) begin
                    n_valid++;
                    last_data = P_DATA;
                    last_perr = PAR_ERR;
                    last_ferr = FRM_ERR;
                end
                if (BRK_DET) n_brk++;
                if (expq.size() == 0) begin
                    check("unexpected_strobe", {DATA_VALID, BRK_DET}, 0);
                end else begin
                    e = expq.pop_front();
                    check("strobe_kind", {DATA_VALID, BRK_DET}, e.brk ? 2'b01 : 2'b10);
                    if (!e.brk) begin
                        check("p_data", P_DATA, e.data);
                        check("par_err", PAR_ERR, e.perr);
                        check("frm_err", FRM_ERR, e.ferr);
                    end
                end
                $display("strobe: valid=%0b brk=%0b data=%03h perr=%0b ferr=%0b",
                         DATA_VALID, BRK_DET, P_DATA, PAR_ERR, FRM_ERR);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input bit v, input int p, input int glitch_at);
        for (int c = 0; c < p; c++) begin
            RX_IN = (c == glitch_at) ? ~v : v;
            tick();
        end
    endtask

    task automatic send_frame(input int p_in, input int len_in, input bit pen, input bit ptyp,
                              input bit st2, input logic [DW-1:0] d, input bit pbit,
                              input bit [1:0] stops, input bit glitch);
        int p;
        int len;
        p   = (p_in < 8) ? 8 : p_in;
        len = (len_in < 5) ? 5 : ((len_in > DW) ? DW : len_in);
        PRESCALE = PW'(p_in);
        DATA_LEN = 4'(len_in);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = st2;
        expq.push_back(model(len_in, pen, ptyp, st2, d, pbit, stops));
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < len; i++) drive_bit(d[i], p, glitch ? p / 2 : -1);
        if (pen) drive_bit(pbit, p, -1);
        drive_bit(stops[0], p, -1);
        if (st2) drive_bit(stops[1], p, -1);
        RX_IN = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && expq.size() != 0; i++) tick();
        check(name, expq.size(), 0);
    endtask

    task automatic expect_frame(input string name, input int v0, input logic [DW-1:0] d,
                                input bit pe, input bit fe);
        wait_drain({name, "_drain"});
        check({name, "_count"}, n_valid - v0, 1);
        check({name, "_data"}, last_data, d);
        check({name, "_perr"}, last_perr, pe);
        check({name, "_ferr"}, last_ferr, fe);
        $display("frame %s: data=%03h perr=%0b ferr=%0b", name, last_data, last_perr, last_ferr);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int v0;
        int b0;
        repeat (3) tick();
        check("rst_outputs", {P_DATA, DATA_VALID, PAR_ERR, FRM_ERR, BRK_DET, BUSY}, 0);
        RST = 1'b1;
        repeat (5) tick();

        v0 = n_valid;
        send_frame(16, 8, 0, 0, 0, 9'h0A5, 0, 2'b11, 0);
        expect_frame("8n1_a5", v0, 9'h0A5, 0, 0);

        v0 = n_valid;
        send_frame(8, 7, 1, 1, 0, 9'h035, 1, 2'b11, 0);
        expect_frame("7e1_bad_par", v0, 9'h035, 1, 0);
        v0 = n_valid;
        send_frame(8, 7, 1, 1, 0, 9'h035, 0, 2'b11, 0);
        expect_frame("7e1_good_par", v0, 9'h035, 0, 0);

        v0 = n_valid;
        send_frame(16, 9, 0, 0, 1, 9'h1FF, 0, 2'b01, 0);
        expect_frame("9n2_bad_stop2", v0, 9'h1FF, 0, 1);
        v0 = n_valid;
        send_frame(16, 9, 0, 0, 1, 9'h1FF, 0, 2'b11, 0);
        expect_frame("9n2_good", v0, 9'h1FF, 0, 0);

        // False start: 4-cycle low pulse.
        PRESCALE = PW'(16);
        v0 = n_valid;
        b0 = n_brk;
        RX_IN = 1'b0;
        repeat (4) tick();
        RX_IN = 1'b1;
        tick();
        check("false_start_busy_hi", BUSY, 1);
        repeat (20) tick();
        check("false_start_busy_lo", BUSY, 0);
        check("false_start_no_valid", n_valid - v0, 0);
        check("false_start_no_brk", n_brk - b0, 0);
        v0 = n_valid;
        send_frame(16, 8, 0, 0, 0, 9'h03C, 0, 2'b11, 0);
        expect_frame("after_false_start", v0, 9'h03C, 0, 0);

        // Break: line low for 12 bit times.
        PRESCALE = PW'(16);
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        v0 = n_valid;
        b0 = n_brk;
        expq.push_back(model(8, 0, 0, 0, 9'h000, 0, 2'b00));
        RX_IN = 1'b0;
        repeat (12 * 16) tick();
        wait_drain("brk_drain");
        check("brk_count", n_brk - b0, 1);
        check("brk_no_valid", n_valid - v0, 0);
        check("brk_busy_low_line", BUSY, 1);
        RX_IN = 1'b1;
        repeat (12) tick();
        check("brk_busy_wait", BUSY, 1);
        repeat (8) tick();
        check("brk_busy_released", BUSY, 0);
        v0 = n_valid;
        send_frame(16, 8, 0, 0, 0, 9'h05A, 0, 2'b11, 0);
        expect_frame("after_brk", v0, 9'h05A, 0, 0);
        check("brk_single_pulse", n_brk - b0, 1);

        v0 = n_valid;
        send_frame(16, 8, 0, 0, 0, 9'h096, 0, 2'b11, 1);
        expect_frame("glitch_96", v0, 9'h096, 0, 0);

        // Reset in the middle of DATA: no strobe, everything cleared.
        v0 = n_valid;
        RX_IN = 1'b0;
        repeat (16) tick();
        RX_IN = 1'b1;
        repeat (16) tick();
        RX_IN = 1'b0;
        repeat (8) tick();
        RST = 1'b0;
        tick();
        check("midframe_rst_outputs", {P_DATA, DATA_VALID, PAR_ERR, FRM_ERR, BRK_DET, BUSY}, 0);
        RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        repeat (20) tick();
        check("midframe_rst_no_valid", n_valid - v0, 0);
        send_frame(16, 8, 0, 0, 0, 9'h011, 0, 2'b11, 0);
        expect_frame("after_rst_11", v0, 9'h011, 0, 0);

        // Configuration clamping: PRESCALE 4 -> 8, DATA_LEN 3 -> 5, DATA_LEN 15 -> 9.
        v0 = n_valid;
        send_frame(4, 3, 0, 0, 0, 9'h015, 0, 2'b11, 0);
        expect_frame("clamp_low", v0, 9'h015, 0, 0);
        v0 = n_valid;
        send_frame(8, 15, 1, 0, 0, 9'h1AB, 1, 2'b11, 0);
        expect_frame("clamp_high_odd", v0, 9'h1AB, 0, 0);

        repeat (10) tick();
        check("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
